// File: rtl/pow2_clk_divider.sv
// Power-of-two clock divider: registered 50%-duty outClk = inClk / 2^activeN plus a one-cycle tick.
// Exponent changes are deferred to a period boundary. Optional phase clear: CLKDIV_PHASE_CLEAR_EN.
module pow2_clk_divider #(
   parameter int unsigned MAX_N   = 12,
   parameter int unsigned N_W     = 4,
   parameter int unsigned RESET_N = 1
) (
   input  logic           inClk,
   input  logic           rstN,
   input  logic           enable,
   input  logic [N_W-1:0] n,
   input  logic           nLoad,
`ifdef CLKDIV_PHASE_CLEAR_EN
   input  logic           phaseClr,
`endif
   output logic           nPending,
   output logic [N_W-1:0] activeN,
   output logic           outClk,
   output logic           tick
);

   typedef enum logic [0:0] {StIdle, StPend} state_e;

   state_e           st_q, st_d;
   logic [MAX_N-1:0] cnt_q, cnt_d;
   logic [N_W-1:0]   active_n_q, active_n_d;
   logic [N_W-1:0]   pend_n_q, pend_n_d;
   logic             out_clk_q, out_clk_d;
   logic             tick_q, tick_d;

   logic [MAX_N-1:0] mask;
   logic [MAX_N-1:0] half;
   logic [MAX_N-1:0] cnt_inc;
   logic             at_bnd;

   function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] v);
      if (v == '0) begin
         return N_W'(1);
      end else if (v > N_W'(MAX_N)) begin
         return N_W'(MAX_N);
      end else begin
         return v;
      end
   endfunction

   always_comb begin
      // mask keeps the low activeN bits; half is its top bit (2^(a-1))
      mask    = ~({MAX_N{1'b1}} << active_n_q);
      half    = mask ^ (mask >> 1);
      cnt_inc = (cnt_q + MAX_N'(1)) & mask;
      at_bnd  = enable && ((cnt_q & mask) == mask);

      st_d       = st_q;
      cnt_d      = cnt_q;
      active_n_d = active_n_q;
      pend_n_d   = pend_n_q;
      out_clk_d  = out_clk_q;
      tick_d     = 1'b0;

      if (enable) begin
         cnt_d     = cnt_inc;
         out_clk_d = |(cnt_inc & half);
         tick_d    = (cnt_inc == half);
      end

      // At a boundary cnt_inc is already 0, so outClk falls as the new ratio starts
      if (st_q == StPend && at_bnd) begin
         active_n_d = pend_n_q;
         cnt_d      = '0;
         st_d       = StIdle;
      end

      if (nLoad) begin
         pend_n_d = clamp_n(n);
         st_d     = StPend;
      end

`ifdef CLKDIV_PHASE_CLEAR_EN
      if (phaseClr) begin
         cnt_d      = '0;
         out_clk_d  = 1'b0;
         tick_d     = 1'b0;
         pend_n_d   = pend_n_q;
         active_n_d = (st_q == StPend) ? pend_n_q : active_n_q;
         st_d       = StIdle;
      end
`endif
   end

   always_ff @(posedge inClk or negedge rstN) begin
      if (!rstN) begin
         st_q       <= StIdle;
         cnt_q      <= '0;
         active_n_q <= N_W'(RESET_N);
         pend_n_q   <= N_W'(RESET_N);
         out_clk_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         active_n_q <= active_n_d;
         pend_n_q   <= pend_n_d;
         out_clk_q  <= out_clk_d;
         tick_q     <= tick_d;
      end
   end

   assign nPending = (st_q == StPend);
   assign activeN  = active_n_q;
   assign outClk   = out_clk_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_pow2_clk_divider.sv
// Directed self-checking bench for pow2_clk_divider (default parameters, RESET_N = 1).
module tb_pow2_clk_divider;

   localparam int unsigned MaxN = 12;
   localparam int unsigned NW   = 4;

   logic          inClk = 1'b0;
   logic          rstN;
   logic          enable;
   logic [NW-1:0] n;
   logic          nLoad;
`ifdef CLKDIV_PHASE_CLEAR_EN
   logic          phaseClr = 1'b0;
`endif
   logic          nPending;
   logic [NW-1:0] activeN;
   logic          outClk;
   logic          tick;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   pow2_clk_divider #(
      .MAX_N  (MaxN),
      .N_W    (NW),
      .RESET_N(1)
   ) u_dut (
      .inClk   (inClk),
      .rstN    (rstN),
      .enable  (enable),
      .n       (n),
      .nLoad   (nLoad),
`ifdef CLKDIV_PHASE_CLEAR_EN
      .phaseClr(phaseClr),
`endif
      .nPending(nPending),
      .activeN (activeN),
      .outClk  (outClk),
      .tick    (tick)
   );

   always #5 inClk = ~inClk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge inClk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] obs_out, obs_tick, obs_pend;
      int unsigned ticks, highs, first_tick, lat;
      logic        bad_act, bad_pend;

      rstN = 1'b0; enable = 1'b0; nLoad = 1'b0; n = '0;
      #12;
      check_eq("rst_out", 32'(outClk), 32'd0);
      check_eq("rst_tick", 32'(tick), 32'd0);
      check_eq("rst_pend", 32'(nPending), 32'd0);
      check_eq("rst_active", 32'(activeN), 32'd1);

      // Divide by 2 out of reset
      rstN = 1'b1; enable = 1'b1;
      obs_out = '0; obs_tick = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         obs_out[k] = outClk; obs_tick[k] = tick;
      end
      check_eq("div2_out", obs_out, 32'h5);
      check_eq("div2_tick", obs_tick, 32'h5);

      // Load n=3 from cnt=0: captured now, applied at the next edge (boundary)
      n = 4'd3; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      check_eq("n3_pending", 32'(nPending), 32'd1);
      step();
      check_eq("n3_active", 32'(activeN), 32'd3);
      check_eq("n3_pend_clr", 32'(nPending), 32'd0);
      check_eq("n3_out_low", 32'(outClk), 32'd0);
      obs_out = '0; obs_tick = '0;
      for (int k = 0; k < 16; k++) begin
         step();
         obs_out[k] = outClk; obs_tick[k] = tick;
      end
      check_eq("div8_out", obs_out, 32'h7878);
      check_eq("div8_tick", obs_tick, 32'h0808);

      // Switch to n=4 (applied after 8 edges)
      n = 4'd4; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      for (int k = 1; k < 8; k++) step();
      check_eq("n4_active", 32'(activeN), 32'd4);
      check_eq("n4_pend_clr", 32'(nPending), 32'd0);

      // At n=4, request n=1 while outClk high; high phase must complete
      n = 4'd1;
      obs_out = '0; obs_pend = '0;
      for (int k = 0; k < 20; k++) begin
         nLoad = (k == 9);
         step();
         obs_out[k] = outClk; obs_pend[k] = nPending;
      end
      nLoad = 1'b0;
      check_eq("n4to1_out", obs_out, 32'h0005_7F80);
      check_eq("n4to1_pend", obs_pend, 32'h0000_7E00);
      check_eq("n4to1_active", 32'(activeN), 32'd1);

      // Clamp n=0 -> 1
      n = 4'd0; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      step();
      check_eq("clamp0_active", 32'(activeN), 32'd1);
      check_eq("clamp0_pend", 32'(nPending), 32'd0);

      // Clamp n=15 -> MAX_N
      n = 4'd15; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      step();
      check_eq("clamp15_active", 32'(activeN), 32'd12);
      ticks = 0; highs = 0; first_tick = 0;
      for (int k = 1; k <= 8192; k++) begin
         step();
         if (tick) begin
            ticks++;
            if (first_tick == 0) first_tick = k;
         end
         if (outClk) highs++;
      end
      check_eq("div4096_ticks", ticks, 32'd2);
      check_eq("div4096_highs", highs, 32'd4096);
      check_eq("div4096_first", first_tick, 32'd2048);

      // Request n=2 at a=12: latency is a full 4096-cycle period
      n = 4'd2; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      lat = 1;
      while (nPending && lat < 5000) begin
         step();
         lat++;
      end
      check_eq("n2_latency", lat, 32'd4096);
      check_eq("n2_active", 32'(activeN), 32'd2);

      // enable=0 for 5 cycles in high phase; nLoad still captured
      step();
      step();
      check_eq("n2_rise_out", 32'(outClk), 32'd1);
      check_eq("n2_rise_tick", 32'(tick), 32'd1);
      enable = 1'b0;
      ticks = 0; highs = 0;
      for (int k = 0; k < 5; k++) begin
         nLoad = (k == 0);
         step();
         if (tick) ticks++;
         if (outClk) highs++;
      end
      nLoad = 1'b0;
      check_eq("hold_ticks", ticks, 32'd0);
      check_eq("hold_out", highs, 32'd5);
      check_eq("hold_pend", 32'(nPending), 32'd1);
      check_eq("hold_active", 32'(activeN), 32'd2);
      enable = 1'b1;
      step();
      check_eq("resume_out1", 32'(outClk), 32'd1);
      step();
      check_eq("resume_out0", 32'(outClk), 32'd0);
      check_eq("resume_pend", 32'(nPending), 32'd0);

      // Move to n=5, then reset mid-period with a pending request
      n = 4'd5; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      for (int k = 1; k < 4; k++) step();
      check_eq("n5_active", 32'(activeN), 32'd5);
      for (int k = 0; k < 20; k++) step();
      check_eq("n5_high", 32'(outClk), 32'd1);
      n = 4'd3; nLoad = 1'b1;
      step();
      nLoad = 1'b0;
      check_eq("n5_pend", 32'(nPending), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      check_eq("midrst_out", 32'(outClk), 32'd0);
      check_eq("midrst_tick", 32'(tick), 32'd0);
      check_eq("midrst_pend", 32'(nPending), 32'd0);
      check_eq("midrst_active", 32'(activeN), 32'd1);
      #1;
      rstN = 1'b1;
      bad_act = 1'b0; bad_pend = 1'b0; highs = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (activeN != 4'd1) bad_act = 1'b1;
         if (nPending) bad_pend = 1'b1;
         if (outClk) highs++;
      end
      check_eq("postrst_active_held", 32'(bad_act), 32'd0);
      check_eq("postrst_no_pend", 32'(bad_pend), 32'd0);
      check_eq("postrst_highs", highs, 32'd20);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pow2_clk_divider.md
Name: pow2_clk_divider

Overview:
- Parametrised, fully synchronous power-of-two clock divider for the 100 MHz system clock.
- Produces a registered 50%-duty divided clock `outClk = inClk / 2^a` and a one-cycle `tick` enable in the `inClk` domain.
- The divide exponent is programmable at run time. Changes are deferred to a period boundary, so the output never shows a runt or glitch.
- Replaces ripple-chained toggle dividers. Sits between the clock source and slow peripherals that use either `outClk` or `tick`.

Parameters:
- MAX_N, 12: largest legal exponent; internal counter width in bits (1..16).
- N_W, 4: width of the exponent input; must satisfy 2^N_W > MAX_N.
- RESET_N, 1: exponent active after reset (1..MAX_N).

Ports:
- inClk  input  1  system clock; all logic on its rising edge.
- rstN  input  1  asynchronous, active-low reset.
- enable  input  1  run when 1; freeze when 0.
- n  input  N_W  requested exponent, sampled only when nLoad=1.
- nLoad  input  1  one-cycle strobe; capture n as the pending exponent.
- nPending  output  1  1 while a captured exponent awaits its boundary.
- activeN  output  N_W  exponent currently in effect.
- outClk  output  1  registered divided clock, period 2^activeN cycles.
- tick  output  1  registered one-cycle pulse, asserted in the cycle outClk rises.

Behaviour:
- Reset (rstN=0, asynchronous):
  - Counter cnt[MAX_N-1:0] = 0; outClk = 0; tick = 0; nPending = 0.
  - activeN = pendN = RESET_N.
- Clamping on capture:
  - n=0 is stored as 1.
  - n>MAX_N is stored as MAX_N.
  - Otherwise n is stored unchanged.
  - All registered exponents are always in 1..MAX_N.
- Run (enable=1), with a = activeN:
  - cnt increments, wrapping modulo 2^a. Only the low a bits are used; upper bits are held at 0.
  - outClk <= bit (a-1) of the next cnt. outClk is low for 2^(a-1) cycles, then high for 2^(a-1) cycles.
  - tick <= 1 exactly when the next low a bits equal 2^(a-1); otherwise 0.
- Timing after reset with n=3:
  - outClk first rises and tick pulses on the 4th rising edge after rstN deasserts with enable=1.
  - outClk falls on the 8th edge; period is 8 thereafter.
- Boundary: the cycle in which the low a bits of cnt are all ones and enable=1. At that edge cnt wraps to 0 and outClk falls.
- Ratio-change state machine (two states):
  - IDLE (nPending=0): nLoad=1 -> pendN <= clamp(n), go to PEND.
  - PEND (nPending=1):
    - At a boundary: activeN <= pendN, cnt <= 0, return to IDLE.
    - nLoad=1 while in PEND, not at a boundary: overwrite pendN; latest request wins.
  - nLoad coinciding with a boundary:
    - Any already-pending value is applied at this boundary.
    - The new value is captured and nPending is 1 afterwards; it is applied at the next boundary.
  - Loading a value equal to activeN still goes through PEND; the output is unaffected.
- Glitch-freedom: the old ratio completes its full high phase; the new ratio starts with a full low phase. No outClk pulse is shorter than 2^(min(old,new)-1) cycles.
- enable=0:
  - cnt, outClk and activeN hold; tick = 0.
  - No boundary occurs, so no switch is applied.
  - nLoad is still captured.
- Reset asserted mid-period: all outputs return to reset values immediately. Any pending request is discarded.
- Latency: capture to switch is at most 2^activeN cycles while enabled.

Optional Feature:
- Macro: CLKDIV_PHASE_CLEAR_EN.
- When defined:
  - Adds input `phaseClr` (1 bit).
  - phaseClr=1 synchronously forces cnt <= 0, outClk <= 0, tick <= 0 on the next edge, regardless of enable.
  - If nPending=1, the pending exponent is applied at that same edge and nPending clears.
  - phaseClr has priority over nLoad capture in that cycle (nLoad is ignored).
- When undefined: the port does not exist and there is no phase-clear logic.

Test Plan:
- Reset with RESET_N=1, enable=1 -> outClk toggles every cycle; tick on every second edge; activeN=1; nPending=0.
- nLoad with n=3 -> nPending=1 until the next boundary, then activeN=3. outClk period is 8 (4 low, 4 high); tick is one cycle per 8.
- Running at n=4, nLoad n=1 while outClk is high:
  - outClk stays high for its full 8 cycles and nPending stays 1 throughout.
  - Switch at the boundary, then period 2.
  - No pulse shorter than 1 cycle low or high.
- Clamping: nLoad n=0 -> activeN=1. nLoad n=15 -> activeN=12, period 4096 cycles, tick count 1 per 4096.
- enable=0 for 5 cycles mid-period at n=2 -> outClk, cnt and activeN hold; tick=0. Resumes in the same phase once enable returns to 1.
- rstN pulsed low with nPending=1 at n=5 -> outClk=0, tick=0, nPending=0, activeN=RESET_N immediately. The request is not applied afterwards.
